imem_loader: RTL and testbench

- Hardware boot loader for the single-cycle RV32I core.
- Receives a byte stream on a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes each word into the byte-addressed instruction memory write port, holding the core in reset until the program is fully loaded.
- Writer-side counterpart of the core's instruction fetch read port; replaces backdoor memory preloading in system-level simulation and on hardware.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/loader_word_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package rv32i_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        FINISH
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int WORD_W         = 32;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs accepted stream bytes little-endian into 32-bit words; word_valid pulses
// the cycle after the lane-3 byte and word holds its value between pulses.
module loader_word_assembler
    import rv32i_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [1:0]        lane,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    // Lanes 0..2 of the word in progress; the newest byte enters at the top.
    logic [WORD_W-9:0] sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane       <= 2'd0;
            sh         <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= 2'd0;
            end else if (byte_en) begin
                sh   <= {byte_in, sh[WORD_W-9:8]};
                lane <= lane + 2'd1;
                if (lane == 2'(BYTES_PER_WORD - 1)) begin
                    word       <= {byte_in, sh};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header + payload bytes -> imem word writes, core held in reset
// until done. Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import rv32i_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam int unsigned CAP_WORDS = 2 ** (ADDR_W - 2);

    // Stream handshake: a byte moves on a rising edge where s_valid && s_ready;
    // s_ready is registered and s_data is don't-care while it is low.
    loader_state_t    state;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             acc;
    logic             data_acc;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]       csum;
`endif

    assign acc       = s_valid && s_ready;
    assign data_acc  = acc && (state == DATA);
    assign len_full  = LEN_W'({s_data, len_lo});
    assign dbg_state = state;

    loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == IDLE && start),
        .byte_en    (data_acc),
        .byte_in    (s_data),
        .lane       (lane),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            imem_addr  <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            word_idx   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LEN0;
                        s_ready    <= 1'b1;
                        busy       <= 1'b1;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_idx   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                LEN0: begin
                    if (acc) begin
                        len_lo <= s_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (acc) begin
                        len <= len_full;
                        if (len_full == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state   <= CSUM;
`else
                            state   <= FINISH;
                            s_ready <= 1'b0;
`endif
                        end else if (32'(len_full) > CAP_WORDS) begin
                            // Oversized programs are rejected before any write.
                            err     <= 1'b1;
                            state   <= FINISH;
                            s_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (acc) begin
`ifdef IMEM_LOADER_CSUM_EN
                        csum <= csum ^ s_data;
`endif
                        if (lane == 2'(BYTES_PER_WORD - 1)) begin
                            imem_addr <= {word_idx[ADDR_W-3:0], 2'b00};
                            word_idx  <= word_idx + LEN_W'(1);
                            if (word_idx + LEN_W'(1) == len) begin
`ifdef IMEM_LOADER_CSUM_EN
                                state   <= CSUM;
`else
                                state   <= FINISH;
                                s_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                CSUM: begin
                    if (acc) begin
                        if (s_data != csum) err <= 1'b1;
                        state   <= FINISH;
                        s_ready <= 1'b0;
                    end
                end
`endif
                FINISH: begin
                    // Release happens a cycle after the final write strobe.
                    busy    <= 1'b0;
                    s_ready <= 1'b0;
                    if (!err) begin
                        done       <= 1'b1;
                        core_reset <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load sessions, random sessions
// against a byte-stream model, and hand sequences for reset and checksum cases.
module tb_imem_loader;
    import rv32i_loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 16;
    localparam int CAP    = 64;

    logic              clk;
    logic              reset;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    imem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // scoreboard: expected {addr, data} of each imem write, in order
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] mon_e;

    logic [31:0] prog [6];

    typedef struct {
        string name;
        int    len;
        int    src;      // 0 random words, 1 fixed program, 2 nop word
        int    gap_max;
        logic  exp_done;
        logic  exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_we: got write addr %0h data %0h required no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("imem_write", {imem_addr, imem_wdata}, mon_e);
            end
        end
    end

    // driver tasks
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (s_ready !== 1'b1 && n <= 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready %b after %0d cycles, required 1", s_ready, n);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_s_ready"}, s_ready, 0);
        check({name, "_imem_we"}, imem_we, 0);
        check({name, "_imem_addr"}, imem_addr, 0);
        check({name, "_imem_wdata"}, imem_wdata, 0);
        check({name, "_core_reset"}, core_reset, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_err"}, err, 0);
        check({name, "_state"}, dbg_state, IDLE);
    endtask

    // One load session; expected writes come from the byte-level model below.
    task automatic run_session(input string name, input int len, input int src, input int gap_max,
                               input logic bad_csum, input logic exp_done, input logic exp_err);
        logic [7:0]  bytes_q[$];
        logic [7:0]  x;
        logic [31:0] w;
        logic [15:0] l;
        l = 16'(len);
        x = 8'h00;
        if (len <= CAP) begin
            for (int i = 0; i < len; i++) begin
                w = (src == 1) ? prog[i] : (src == 2) ? 32'h0000_0013 : $urandom;
                exp_q.push_back({ADDR_W'(i * 4), w});
                for (int k = 0; k < 4; k++) begin
                    bytes_q.push_back(w[8*k +: 8]);
                    x = x ^ w[8*k +: 8];
                end
            end
        end
        do_start();
        check({name, "_busy_at_start"}, busy, 1);
        check({name, "_done_at_start"}, done, 0);
        send_byte(l[7:0], 0);
        send_byte(l[15:8], $urandom_range(gap_max, 0));
        foreach (bytes_q[i]) send_byte(bytes_q[i], $urandom_range(gap_max, 0));
`ifdef IMEM_LOADER_CSUM_EN
        if (len <= CAP) send_byte(bad_csum ? (x ^ 8'h5A) : x, $urandom_range(gap_max, 0));
`else
        if (len > 0 && len <= CAP) begin
            check({name, "_we_last"}, imem_we, 1);
            check({name, "_done_early"}, done, 0);
            check({name, "_core_reset_early"}, core_reset, 1);
        end
        if (bad_csum) check({name, "_no_csum_stream"}, bad_csum, 0);
`endif
        @(posedge clk); #1;
        check({name, "_done"}, done, exp_done);
        check({name, "_err"}, err, exp_err);
        check({name, "_core_reset"}, core_reset, !exp_done);
        check({name, "_busy"}, busy, 0);
        check({name, "_s_ready"}, s_ready, 0);
        check({name, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int   len;
        logic bad;
        logic m_err;

        prog = '{32'h0100_0093, 32'h0100_8113, 32'h4011_01B3,
                 32'h0011_9233, 32'h0030_A023, 32'h0000_A283};

        vecs[0] = '{"prog6",       6,          1, 0, 1'b1, 1'b0};
        vecs[1] = '{"empty",       0,          0, 0, 1'b1, 1'b0};
        vecs[2] = '{"prog6_stall", 6,          1, 5, 1'b1, 1'b0};
        vecs[3] = '{"ovf65",       65,         0, 0, 1'b0, 1'b1};
        vecs[4] = '{"restart_nop", 1,          2, 0, 1'b1, 1'b0};
        vecs[5] = '{"full64",      64,         0, 0, 1'b1, 1'b0};
        vecs[6] = '{"ovf_ffff",    16'hFFFF,   0, 2, 1'b0, 1'b1};
        vecs[7] = '{"ovf_0100",    16'h0100,   0, 1, 1'b0, 1'b1};

        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #12;
        check_reset_vals("por");
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_s_ready", s_ready, 0);

        foreach (vecs[i])
            run_session(vecs[i].name, vecs[i].len, vecs[i].src, vecs[i].gap_max,
                        1'b0, vecs[i].exp_done, vecs[i].exp_err);

        // random sessions against the model: overflow iff len exceeds capacity
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(70, 0);
`ifdef IMEM_LOADER_CSUM_EN
            bad = 1'($urandom_range(1, 0));
`else
            bad = 1'b0;
`endif
            m_err = (len > CAP) || bad;
            run_session($sformatf("rand%0d", r), len, 0, 3, bad, !m_err, m_err);
        end

        // reset in the middle of a 6-word load
        for (int i = 0; i < 6; i++) exp_q.push_back({ADDR_W'(i * 4), prog[i]});
        do_start();
        send_byte(8'd6, 0);
        send_byte(8'd0, 0);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) send_byte(prog[i][8*k +: 8], 0);
        @(posedge clk); #1;
        check("midrst_writes_seen", exp_q.size(), 4);
        check("midrst_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("midrst_start_ignored_busy", busy, 0);
        check("midrst_start_ignored_ready", s_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_session("reload", 6, 1, 0, 1'b0, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
        run_session("csum_ok",  1, 2, 0, 1'b0, 1'b1, 1'b0);
        run_session("csum_bad", 1, 2, 0, 1'b1, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
